// File: rtl/reg_write_ctrl_if.sv
// Register-file write port driven by reg_write_ctrl.
// master = controller side, slave = register file / observer side.
interface reg_write_ctrl_if;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        Busy;

    modport master (
        output W_Addr,
        output W_Data,
        output Write_Reg,
        output Busy
    );

    modport slave (
        input W_Addr,
        input W_Data,
        input Write_Reg,
        input Busy
    );
endinterface

// File: rtl/reg_write_ctrl.sv
// Debounced push-button to register-file write controller.
// Single write of a pattern, or a 32-cycle fill burst of pattern+address.
module reg_write_ctrl #(
    parameter int DB_COUNT = 260000,
    parameter int CNT_W    = 18
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Btn,
    input  logic             Fill,
    input  logic [1:0]       CS,
    input  logic [4:0]       Addr_In,
    reg_write_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        WRITE,
        FILL,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       k;
    logic [1:0]       sync;
    logic [1:0]       lat_cs;
    logic             btn_s;

    assign btn_s = sync[1];

    function automatic logic [31:0] pat(input logic [1:0] sel);
        logic [31:0] p;
        unique case (sel)
            2'b00:   p = 32'h1234_5678;
            2'b01:   p = 32'h89AB_CDEF;
            2'b10:   p = 32'h7FFF_FFFF;
            default: p = 32'hFFFF_FFFF;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            k             <= '0;
            sync          <= '0;
            lat_cs        <= '0;
            bus.W_Addr    <= '0;
            bus.W_Data    <= '0;
            bus.Write_Reg <= 1'b0;
            bus.Busy      <= 1'b0;
        end else begin
            sync <= {sync[0], Btn};
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state    <= DEBOUNCE;
                        cnt      <= '0;
                        bus.Busy <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end else if (cnt == DB_LAST) begin
                        // Command latched here; later switch moves are ignored
                        lat_cs        <= CS;
                        bus.Write_Reg <= 1'b1;
                        bus.W_Data    <= pat(CS);
                        if (Fill) begin
                            state      <= FILL;
                            k          <= '0;
                            bus.W_Addr <= '0;
                        end else begin
                            state      <= WRITE;
                            bus.W_Addr <= Addr_In;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    state         <= RELEASE;
                    cnt           <= '0;
                    bus.Write_Reg <= 1'b0;
                    bus.W_Addr    <= '0;
                    bus.W_Data    <= '0;
                end
                FILL: begin
                    if (k == 5'd31) begin
                        state         <= RELEASE;
                        k             <= '0;
                        cnt           <= '0;
                        bus.Write_Reg <= 1'b0;
                        bus.W_Addr    <= '0;
                        bus.W_Data    <= '0;
                    end else begin
                        k          <= k + 5'd1;
                        bus.W_Addr <= k + 5'd1;
                        bus.W_Data <= pat(lat_cs) + {27'd0, k} + 32'd1;
                    end
                end
                RELEASE: begin
                    if (btn_s) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench for reg_write_ctrl with DB_COUNT=4.
// Cycle table for a single write, plus fill/reset/hold sequences.
module tb_reg_write_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Btn;
    logic       Fill;
    logic [1:0] CS;
    logic [4:0] Addr_In;

    int checks = 0;
    int errors = 0;

    reg_write_ctrl_if bus ();

    reg_write_ctrl #(
        .DB_COUNT(4),
        .CNT_W   (18)
    ) dut (
        .clk    (clk),
        .Reset  (Reset),
        .Btn    (Btn),
        .Fill   (Fill),
        .CS     (CS),
        .Addr_In(Addr_In),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        btn;
        logic [1:0]  cs;
        logic [4:0]  addr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        busy;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_we"}, {31'd0, bus.Write_Reg}, 32'd0);
        chk({name, "_addr"}, {27'd0, bus.W_Addr}, 32'd0);
        chk({name, "_data"}, bus.W_Data, 32'd0);
        chk({name, "_busy"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic release_btn(input string name);
        int n;
        n = 0;
        Btn = 1'b0;
        while (bus.Busy && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_release_busy"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic run_fill(input logic [1:0] cs, input logic [31:0] base,
                            input string name);
        int n;
        n = 0;
        Btn  = 1'b1;
        Fill = 1'b1;
        CS   = cs;
        do begin
            tick();
            n++;
        end while (!bus.Write_Reg && n < 20);
        chk({name, "_latency"}, n, 32'd7);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                CS   = ~cs;
                Fill = 1'b0;
            end
            chk($sformatf("%s_we%0d", name, i), {31'd0, bus.Write_Reg}, 32'd1);
            chk($sformatf("%s_addr%0d", name, i), {27'd0, bus.W_Addr}, i);
            chk($sformatf("%s_data%0d", name, i), bus.W_Data, base + i);
            tick();
        end
        chk({name, "_end_we"}, {31'd0, bus.Write_Reg}, 32'd0);
        chk({name, "_end_busy"}, {31'd0, bus.Busy}, 32'd1);
        release_btn(name);
    endtask

    initial begin
        int n;
        int pulses;
        logic seen_busy;
        logic [4:0]  cap_addr;
        logic [31:0] cap_data;

        // btn, cs, addr -> we, waddr, wdata, busy (one entry per edge)
        vecs[0]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 2'b01, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 5'd7, 1'b1, 5'd7, 32'h89AB_CDEF, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[15] = '{1'b0, 2'b10, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0};

        Reset   = 1'b1;
        Btn     = 1'b0;
        Fill    = 1'b0;
        CS      = 2'b00;
        Addr_In = 5'd0;
        tick();
        tick();
        chk_idle_outputs("reset");
        Reset = 1'b0;

        // Single write, cycle by cycle
        Fill = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Btn     = vecs[i].btn;
            CS      = vecs[i].cs;
            Addr_In = vecs[i].addr;
            tick();
            chk($sformatf("single_e%0d", i + 1),
                {bus.Write_Reg, bus.Busy, bus.W_Addr, bus.W_Data},
                {vecs[i].we, vecs[i].busy, vecs[i].waddr, vecs[i].wdata});
        end

        // Bounce: 3 cycles high, never writes
        seen_busy = 1'b0;
        pulses    = 0;
        Btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) Btn = 1'b0;
            tick();
            if (bus.Busy) seen_busy = 1'b1;
            if (bus.Write_Reg) pulses++;
        end
        chk("bounce_seen_busy", {31'd0, seen_busy}, 32'd1);
        chk("bounce_pulses", pulses, 32'd0);
        chk("bounce_busy_end", {31'd0, bus.Busy}, 32'd0);

        run_fill(2'b00, 32'h1234_5678, "fill00");
        run_fill(2'b11, 32'hFFFF_FFFF, "fill11");

        // Reset in the middle of a fill
        Btn  = 1'b1;
        Fill = 1'b1;
        CS   = 2'b10;
        n    = 0;
        while (!(bus.Write_Reg && bus.W_Addr == 5'd10) && n < 40) begin
            tick();
            n++;
        end
        chk("midfill_reach_k10", {27'd0, bus.W_Addr}, 32'd10);
        chk("midfill_k10_data", bus.W_Data, 32'h8000_0009);
        Reset = 1'b1;
        tick();
        chk_idle_outputs("midfill_reset");
        Reset = 1'b0;
        Btn   = 1'b0;
        tick();
        tick();
        tick();
        chk("midfill_post_busy", {31'd0, bus.Busy}, 32'd0);
        run_fill(2'b00, 32'h1234_5678, "refill");

        // Long hold: one write only, original command
        Btn     = 1'b1;
        Fill    = 1'b0;
        CS      = 2'b10;
        Addr_In = 5'd12;
        pulses  = 0;
        cap_addr = '0;
        cap_data = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.Write_Reg) begin
                pulses++;
                if (pulses == 1) begin
                    cap_addr = bus.W_Addr;
                    cap_data = bus.W_Data;
                end
            end
            if (i == 8) begin
                CS      = 2'b01;
                Addr_In = 5'd3;
            end
        end
        chk("hold_pulses", pulses, 32'd1);
        chk("hold_addr", {27'd0, cap_addr}, 32'd12);
        chk("hold_data", cap_data, 32'h7FFF_FFFF);
        chk("hold_busy", {31'd0, bus.Busy}, 32'd1);
        release_btn("hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
